// File: rtl/exu_wb_arb.sv
// Writeback arbiter: merges ALU and buffered LSU results into one registered RF write port.
// Optional combinational forwarding from the output register is enabled by defining WB_FWD_EN.
module exu_wb_arb #(
   parameter int unsigned XLEN           = 32,
   parameter int unsigned RFIDX          = 5,
   parameter int unsigned LSU_FIFO_DEPTH = 2
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_alu_rdwen,
   input  logic [RFIDX-1:0] i_alu_rdidx,
   input  logic [XLEN-1:0]  i_alu_rdwdata,
   input  logic             i_lsu_valid,
   output logic             o_lsu_ready,
   input  logic [RFIDX-1:0] i_lsu_rdidx,
   input  logic [XLEN-1:0]  i_lsu_rdwdata,
   output logic             o_rf_wen,
   output logic [RFIDX-1:0] o_rf_widx,
   output logic [XLEN-1:0]  o_rf_wdata,
   output logic             o_wb_busy,
   input  logic [RFIDX-1:0] i_fwd_rsidx,
   output logic             o_fwd_hit,
   output logic [XLEN-1:0]  o_fwd_data
);

   localparam int unsigned PW = $clog2(LSU_FIFO_DEPTH);
   localparam int unsigned CW = $clog2(LSU_FIFO_DEPTH + 1);
   localparam logic [CW-1:0] FullCnt = CW'(LSU_FIFO_DEPTH);

   logic [RFIDX-1:0]          fifo_idx_q  [LSU_FIFO_DEPTH];
   logic [XLEN-1:0]           fifo_data_q [LSU_FIFO_DEPTH];
   logic [LSU_FIFO_DEPTH-1:0] kill_q, kill_d, valid_mask;
   logic [PW-1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0]             count_q, count_d;

   logic             wen_q, wen_d;
   logic [RFIDX-1:0] widx_q, widx_d;
   logic [XLEN-1:0]  wdata_q, wdata_d;

   logic alu_w, lsu_xfer, pop, bypass, push, push_kill;

   assign alu_w       = i_alu_rdwen && (i_alu_rdidx != '0);
   assign o_lsu_ready = (count_q != FullCnt);
   assign o_wb_busy   = (count_q != '0);
   assign lsu_xfer    = i_lsu_valid && o_lsu_ready;
   assign pop         = !alu_w && (count_q != '0);
   assign bypass      = !alu_w && (count_q == '0) && lsu_xfer;
   assign push        = lsu_xfer && !bypass;
   // A same-cycle LSU push is older than the ALU write, so a matching rd is already stale.
   assign push_kill   = (i_lsu_rdidx == '0) || (alu_w && (i_lsu_rdidx == i_alu_rdidx));

   always_comb begin
      valid_mask = '0;
      for (int i = 0; i < LSU_FIFO_DEPTH; i++) begin
         valid_mask[i] = CW'(PW'(i) - rptr_q) < count_q;
      end
   end

   always_comb begin
      kill_d = kill_q;
      for (int i = 0; i < LSU_FIFO_DEPTH; i++) begin
         if (alu_w && valid_mask[i] && (fifo_idx_q[i] == i_alu_rdidx)) kill_d[i] = 1'b1;
      end
      if (push) kill_d[wptr_q] = push_kill;
   end

   always_comb begin
      wptr_d  = push ? wptr_q + PW'(1) : wptr_q;
      rptr_d  = pop  ? rptr_q + PW'(1) : rptr_q;
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Output stage holds idx/data when idle; only wen carries meaning.
   always_comb begin
      wen_d   = 1'b0;
      widx_d  = widx_q;
      wdata_d = wdata_q;
      if (alu_w) begin
         wen_d   = 1'b1;
         widx_d  = i_alu_rdidx;
         wdata_d = i_alu_rdwdata;
      end else if (pop) begin
         if (!kill_q[rptr_q]) begin
            wen_d   = 1'b1;
            widx_d  = fifo_idx_q[rptr_q];
            wdata_d = fifo_data_q[rptr_q];
         end
      end else if (bypass) begin
         wen_d   = 1'b1;
         widx_d  = i_lsu_rdidx;
         wdata_d = i_lsu_rdwdata;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         kill_q  <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         wen_q   <= 1'b0;
         widx_q  <= '0;
         wdata_q <= '0;
         for (int i = 0; i < LSU_FIFO_DEPTH; i++) begin
            fifo_idx_q[i]  <= '0;
            fifo_data_q[i] <= '0;
         end
      end else begin
         kill_q  <= kill_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         wen_q   <= wen_d;
         widx_q  <= widx_d;
         wdata_q <= wdata_d;
         if (push) begin
            fifo_idx_q[wptr_q]  <= i_lsu_rdidx;
            fifo_data_q[wptr_q] <= i_lsu_rdwdata;
         end
      end
   end

   assign o_rf_wen   = wen_q;
   assign o_rf_widx  = widx_q;
   assign o_rf_wdata = wdata_q;

`ifdef WB_FWD_EN
   assign o_fwd_hit  = wen_q && (widx_q == i_fwd_rsidx) && (i_fwd_rsidx != '0);
   assign o_fwd_data = o_fwd_hit ? wdata_q : '0;
`else
   logic unused_fwd_rsidx;
   assign unused_fwd_rsidx = ^i_fwd_rsidx;
   assign o_fwd_hit  = 1'b0;
   assign o_fwd_data = '0;
`endif

endmodule

// File: tb/tb_exu_wb_arb.sv
// Directed self-checking bench for exu_wb_arb; forwarding checks follow WB_FWD_EN.
module tb_exu_wb_arb;

   logic        clk = 1'b0;
   logic        rstn;
   logic        alu_rdwen;
   logic [4:0]  alu_rdidx;
   logic [31:0] alu_rdwdata;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rdidx;
   logic [31:0] lsu_rdwdata;
   logic        rf_wen;
   logic [4:0]  rf_widx;
   logic [31:0] rf_wdata;
   logic        wb_busy;
   logic [4:0]  fwd_rsidx;
   logic        fwd_hit;
   logic [31:0] fwd_data;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   exu_wb_arb dut (
      .i_clk         (clk),
      .i_rstn        (rstn),
      .i_alu_rdwen   (alu_rdwen),
      .i_alu_rdidx   (alu_rdidx),
      .i_alu_rdwdata (alu_rdwdata),
      .i_lsu_valid   (lsu_valid),
      .o_lsu_ready   (lsu_ready),
      .i_lsu_rdidx   (lsu_rdidx),
      .i_lsu_rdwdata (lsu_rdwdata),
      .o_rf_wen      (rf_wen),
      .o_rf_widx     (rf_widx),
      .o_rf_wdata    (rf_wdata),
      .o_wb_busy     (wb_busy),
      .i_fwd_rsidx   (fwd_rsidx),
      .o_fwd_hit     (fwd_hit),
      .o_fwd_data    (fwd_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic alu(input logic en, input logic [4:0] idx, input logic [31:0] data);
      alu_rdwen   = en;
      alu_rdidx   = idx;
      alu_rdwdata = data;
   endtask

   task automatic lsu(input logic vld, input logic [4:0] idx, input logic [31:0] data);
      lsu_valid   = vld;
      lsu_rdidx   = idx;
      lsu_rdwdata = data;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input string tag, input logic [4:0] idx, input logic [31:0] data);
      check({tag, ".wen"},   32'(rf_wen),  32'd1);
      check({tag, ".widx"},  32'(rf_widx), 32'(idx));
      check({tag, ".wdata"}, rf_wdata,     data);
   endtask

   initial begin
      rstn      = 1'b0;
      fwd_rsidx = '0;
      alu(1'b1, 5'd5, 32'h1234);
      lsu(1'b0, 5'd0, 32'h0);

      // Reset held two cycles; the request present during reset is not written
      step();
      check("rst.wen",   32'(rf_wen),    32'd0);
      check("rst.widx",  32'(rf_widx),   32'd0);
      check("rst.wdata", rf_wdata,       32'd0);
      check("rst.busy",  32'(wb_busy),   32'd0);
      check("rst.ready", 32'(lsu_ready), 32'd1);
      step();
      check("rst2.wen",  32'(rf_wen),    32'd0);
      rstn = 1'b1;

      // Test 1: plain ALU write
      step();
      expect_wr("t1", 5'd5, 32'h1234);

      // Test 2: ALU to x0 is not a write; LSU alongside it bypasses
      alu(1'b1, 5'd0, 32'hFFFF_FFFF);
      step();
      check("t2a.wen",  32'(rf_wen),  32'd0);
      check("t2a.hold", 32'(rf_widx), 32'd5);
      lsu(1'b1, 5'd3, 32'hAA);
      step();
      expect_wr("t2b", 5'd3, 32'hAA);
      check("t2b.busy", 32'(wb_busy), 32'd0);

      // Test 3: ALU every cycle fills the buffer, then drains in order
      alu(1'b1, 5'd1, 32'h101);
      lsu(1'b1, 5'd7, 32'h70);
      step();
      expect_wr("t3a", 5'd1, 32'h101);
      check("t3a.ready", 32'(lsu_ready), 32'd1);
      check("t3a.busy",  32'(wb_busy),   32'd1);
      alu(1'b1, 5'd2, 32'h102);
      lsu(1'b1, 5'd8, 32'h80);
      step();
      expect_wr("t3b", 5'd2, 32'h102);
      check("t3b.ready", 32'(lsu_ready), 32'd0);
      alu(1'b1, 5'd1, 32'h103);
      lsu(1'b1, 5'd10, 32'hDEAD);
      step();
      expect_wr("t3c", 5'd1, 32'h103);
      check("t3c.ready", 32'(lsu_ready), 32'd0);
      alu(1'b0, 5'd0, 32'h0);
      lsu(1'b0, 5'd0, 32'h0);
      step();
      expect_wr("t3d", 5'd7, 32'h70);
      check("t3d.ready", 32'(lsu_ready), 32'd1);
      step();
      expect_wr("t3e", 5'd8, 32'h80);
      check("t3e.busy", 32'(wb_busy), 32'd0);
      step();
      check("t3f.wen", 32'(rf_wen), 32'd0);

      // Test 4: newer ALU write to x9 kills the buffered LSU x9
      alu(1'b1, 5'd2, 32'h33);
      lsu(1'b1, 5'd9, 32'h11);
      step();
      expect_wr("t4a", 5'd2, 32'h33);
      alu(1'b1, 5'd9, 32'h22);
      lsu(1'b0, 5'd0, 32'h0);
      step();
      expect_wr("t4b", 5'd9, 32'h22);
      check("t4b.busy", 32'(wb_busy), 32'd1);
      alu(1'b0, 5'd0, 32'h0);
      step();
      check("t4c.wen",   32'(rf_wen),   32'd0);
      check("t4c.wdata", rf_wdata,      32'h22);
      check("t4c.busy",  32'(wb_busy),  32'd0);

      // Same-cycle push to the ALU's rd is killed on entry
      alu(1'b1, 5'd12, 32'h44);
      lsu(1'b1, 5'd12, 32'h99);
      step();
      expect_wr("t4d", 5'd12, 32'h44);
      alu(1'b0, 5'd0, 32'h0);
      lsu(1'b0, 5'd0, 32'h0);
      step();
      check("t4e.wen",   32'(rf_wen),  32'd0);
      check("t4e.wdata", rf_wdata,     32'h44);

      // LSU to x0 behind an ALU write is accepted but never written
      alu(1'b1, 5'd3, 32'h5);
      lsu(1'b1, 5'd0, 32'hBEEF);
      step();
      expect_wr("t4f", 5'd3, 32'h5);
      check("t4f.busy", 32'(wb_busy), 32'd1);
      alu(1'b0, 5'd0, 32'h0);
      lsu(1'b0, 5'd0, 32'h0);
      step();
      check("t4g.wen",  32'(rf_wen),  32'd0);
      check("t4g.busy", 32'(wb_busy), 32'd0);

      // Test 5: bypass with empty buffer
      lsu(1'b1, 5'd4, 32'h55);
      step();
      expect_wr("t5", 5'd4, 32'h55);
      check("t5.busy", 32'(wb_busy), 32'd0);

      // Test 6: forwarding from the output register
      lsu(1'b1, 5'd6, 32'h77);
      step();
      lsu(1'b0, 5'd0, 32'h0);
      expect_wr("t6", 5'd6, 32'h77);
      fwd_rsidx = 5'd6;
      #1;
`ifdef WB_FWD_EN
      check("t6.hit6",  32'(fwd_hit), 32'd1);
      check("t6.data6", fwd_data,     32'h77);
`else
      check("t6.hit6",  32'(fwd_hit), 32'd0);
      check("t6.data6", fwd_data,     32'd0);
`endif
      fwd_rsidx = 5'd0;
      #1;
      check("t6.hit0",  32'(fwd_hit), 32'd0);
      check("t6.data0", fwd_data,     32'd0);
      fwd_rsidx = 5'd6;
      step();
      check("t6.idle_hit", 32'(fwd_hit), 32'd0);

      // Reset mid-operation discards buffered entries
      alu(1'b1, 5'd1, 32'h1);
      lsu(1'b1, 5'd20, 32'h20);
      step();
      check("t7.busy", 32'(wb_busy), 32'd1);
      rstn = 1'b0;
      step();
      check("t7r.wen",   32'(rf_wen),    32'd0);
      check("t7r.busy",  32'(wb_busy),   32'd0);
      check("t7r.ready", 32'(lsu_ready), 32'd1);
      rstn = 1'b1;
      alu(1'b0, 5'd0, 32'h0);
      lsu(1'b0, 5'd0, 32'h0);
      step();
      check("t7a.wen", 32'(rf_wen), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
